// File: rtl/dmem_bytelane.sv
// Byte-addressable RV32 data memory with load/store sizing, fault detection
// and a sequenced post-reset clear. Reads are combinational, writes commit on clk.
module dmem_bytelane #(
  parameter int DEPTH          = 256,
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           write_data,
  output logic [31:0]           read_data,
  output logic                  ready,
  output logic                  fault
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int WIDX_W = ADDR_WIDTH - 2;

  typedef enum logic {CLEAR, IDLE} state_t;

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] clr_ptr;
  logic [IDX_W-1:0] clr_ptr_next;

  logic [31:0] mem [DEPTH];

  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        lane;
  logic              out_of_range;

  logic        load_legal;
  logic        store_legal;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        illegal;
  logic        do_load;
  logic        do_store;
  logic [31:0] cur_word;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [31:0] load_val;
  logic [3:0]  byte_en;
  logic [31:0] store_word;

  assign word_idx = addr[ADDR_WIDTH-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign lane     = addr[1:0];

  // DEPTH is a power of two, so any set bit above the index field is out of range.
  generate
    if (WIDX_W > IDX_W) begin : g_range
      assign out_of_range = |word_idx[WIDX_W-1:IDX_W];
    end else begin : g_norange
      assign out_of_range = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RESET_STATE;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == IDX_W'(DEPTH - 1)) begin
          state_next   = IDLE;
          clr_ptr_next = '0;
        end
      end
      IDLE:    state_next = IDLE;
      default: state_next = RESET_STATE;
    endcase
  end

  always_comb begin
    load_legal  = 1'b0;
    store_legal = 1'b0;
    case (funct3)
      3'b000, 3'b001, 3'b010: begin
        load_legal  = 1'b1;
        store_legal = 1'b1;
      end
      3'b100, 3'b101: load_legal = 1'b1;
      default: ;
    endcase
  end

  assign is_half    = (funct3[1:0] == 2'b01);
  assign is_word    = (funct3[1:0] == 2'b10);
  assign misaligned = (is_half & addr[0]) | (is_word & (lane != 2'b00));
  assign illegal    = (mem_read & ~load_legal) | (mem_write & ~store_legal);

  assign ready    = (state == IDLE) & ~reset;
  assign fault    = ready & (mem_read | mem_write) & (misaligned | illegal | out_of_range);
  assign do_load  = ready & mem_read & ~fault;
  assign do_store = ready & mem_write & ~fault;

  assign cur_word = mem[mem_idx];
  assign sel_half = lane[1] ? cur_word[31:16] : cur_word[15:0];

  always_comb begin
    sel_byte = cur_word[7:0];
    case (lane)
      2'd0: sel_byte = cur_word[7:0];
      2'd1: sel_byte = cur_word[15:8];
      2'd2: sel_byte = cur_word[23:16];
      2'd3: sel_byte = cur_word[31:24];
      default: ;
    endcase
  end

  always_comb begin
    load_val = '0;
    case (funct3)
      3'b000:  load_val = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  load_val = {{16{sel_half[15]}}, sel_half};
      3'b010:  load_val = cur_word;
      3'b100:  load_val = {24'b0, sel_byte};
      3'b101:  load_val = {16'b0, sel_half};
      default: load_val = '0;
    endcase
  end

  // Gated to zero whenever there is no valid load so X never leaks out.
  assign read_data = do_load ? load_val : 32'b0;

  always_comb begin
    byte_en    = 4'b0000;
    store_word = write_data;
    case (funct3)
      3'b000: begin
        byte_en    = 4'b0001 << lane;
        store_word = {4{write_data[7:0]}};
      end
      3'b001: begin
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
        store_word = {2{write_data[15:0]}};
      end
      3'b010: begin
        byte_en    = 4'b1111;
        store_word = write_data;
      end
      default: ;
    endcase
  end

  // The clear sweep owns the array while in CLEAR; user stores only happen in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else if (do_store) begin
        for (int i = 0; i < 4; i++) begin
          if (byte_en[i]) begin
            mem[mem_idx][8*i +: 8] <= store_word[8*i +: 8];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bytelane.sv
// Self-checking bench for dmem_bytelane: directed cases plus randomized
// accesses compared against a byte-array reference model.
module tb_dmem_bytelane;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [10:0] addr = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_data;
  logic        ready;
  logic        fault;
  logic [31:0] nc_read_data;
  logic        nc_ready;
  logic        nc_fault;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] model_mem [1024];

  always #5 clk = ~clk;

  dmem_bytelane #(.DEPTH(256), .ADDR_WIDTH(11), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data),
    .read_data(read_data), .ready(ready), .fault(fault)
  );

  // Second instance keeps contents across reset.
  dmem_bytelane #(.DEPTH(32), .ADDR_WIDTH(11), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .funct3(funct3), .addr(addr), .write_data(write_data),
    .read_data(nc_read_data), .ready(nc_ready), .fault(nc_fault)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %08h, expected %08h", tag, actual, expected);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic model_fault(input logic rd, input logic wr, input logic [2:0] f3, input logic [10:0] a);
    bit load_ok;
    bit store_ok;
    load_ok  = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    store_ok = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
    if (!(rd || wr)) return 1'b0;
    if (rd && !load_ok) return 1'b1;
    if (wr && !store_ok) return 1'b1;
    if ((int'(a) % size_of(f3)) != 0) return 1'b1;
    if (int'(a) >= 1024) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [10:0] a);
    logic [31:0] v;
    int n;
    n = size_of(f3);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (32'(model_mem[int'(a) + i]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
    return v;
  endfunction

  task automatic clearModel();
    for (int i = 0; i < 1024; i++) model_mem[i] = 8'h00;
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [10:0] a, input logic [31:0] wd);
    @(negedge clk);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    addr       = a;
    write_data = wd;
    #1;
  endtask

  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [10:0] a, input logic [31:0] wd);
    logic        flt;
    logic [31:0] exp_rd;
    applyStimulus(rd, wr, f3, a, wd);
    flt    = model_fault(rd, wr, f3, a);
    exp_rd = (rd && !flt) ? model_load(f3, a) : 32'h0;
    checkOutput({tag, " fault"}, {31'b0, fault}, {31'b0, flt});
    checkOutput({tag, " data"}, read_data, exp_rd);
    if (wr && !flt)
      for (int i = 0; i < size_of(f3); i++) model_mem[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  task automatic loadCheck(input string tag, input logic [2:0] f3, input logic [10:0] a, input logic [31:0] exp_val);
    access(tag, 1'b1, 1'b0, f3, a, 32'h0);
    checkOutput({tag, " literal"}, read_data, exp_val);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    reset     = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    funct3    = 3'b011;
    addr      = '0;
    #1;
    checkOutput("reset ready", {31'b0, ready}, 32'd0);
    checkOutput("reset nc_ready", {31'b0, nc_ready}, 32'd0);
    checkOutput("reset fault", {31'b0, fault}, 32'd0);
    checkOutput("reset data", read_data, 32'h0);
    @(negedge clk);
    reset    = 1'b0;
    mem_read = 1'b0;
    funct3   = 3'b000;
  endtask

  // Counts not-ready cycles after release while hammering a store that must be ignored.
  task automatic countClear(output int n);
    mem_read   = 1'b1;
    mem_write  = 1'b1;
    funct3     = 3'b010;
    addr       = '0;
    write_data = 32'hFFFFFFFF;
    n = 0;
    #1;
    checkOutput("clear fault", {31'b0, fault}, 32'd0);
    checkOutput("clear data", read_data, 32'h0);
    while (!ready && n < 1000) begin
      n++;
      @(negedge clk);
      #1;
    end
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    write_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [10:0] a;
    logic [2:0]  legal_codes [5];
    legal_codes[0] = 3'd0; legal_codes[1] = 3'd1; legal_codes[2] = 3'd2;
    legal_codes[3] = 3'd4; legal_codes[4] = 3'd5;

    repeat (2) @(posedge clk);
    pulseReset();
    countClear(n);
    checkOutput("initial clear cycles", 32'(n), 32'd256);
    clearModel();

    access("preload 000", 1'b0, 1'b1, 3'b010, 11'h000, $urandom | 32'h1);
    access("preload 1FC", 1'b0, 1'b1, 3'b010, 11'h1FC, $urandom | 32'h1);
    access("preload 3FC", 1'b0, 1'b1, 3'b010, 11'h3FC, $urandom | 32'h1);
    pulseReset();
    countClear(n);
    checkOutput("clear cycles", 32'(n), 32'd256);
    clearModel();
    loadCheck("cleared 000", 3'b010, 11'h000, 32'h0);
    loadCheck("cleared 1FC", 3'b010, 11'h1FC, 32'h0);
    loadCheck("cleared 3FC", 3'b010, 11'h3FC, 32'h0);

    pulseReset();
    repeat (100) @(negedge clk);
    #1;
    checkOutput("mid-clear ready", {31'b0, ready}, 32'd0);
    pulseReset();
    countClear(n);
    checkOutput("restart clear cycles", 32'(n), 32'd256);
    clearModel();

    access("sw 010", 1'b0, 1'b1, 3'b010, 11'h010, 32'h80FF7F01);
    loadCheck("lb 010", 3'b000, 11'h010, 32'h00000001);
    loadCheck("lb 011", 3'b000, 11'h011, 32'h0000007F);
    loadCheck("lb 012", 3'b000, 11'h012, 32'hFFFFFFFF);
    loadCheck("lbu 012", 3'b100, 11'h012, 32'h000000FF);
    loadCheck("lb 013", 3'b000, 11'h013, 32'hFFFFFF80);
    loadCheck("lh 012", 3'b001, 11'h012, 32'hFFFF80FF);
    loadCheck("lhu 012", 3'b101, 11'h012, 32'h000080FF);

    access("sw 020", 1'b0, 1'b1, 3'b010, 11'h020, 32'hAAAAAAAA);
    access("sb 021", 1'b0, 1'b1, 3'b000, 11'h021, 32'hCDEF0055);
    access("sh 022", 1'b0, 1'b1, 3'b001, 11'h022, 32'hBEEF1234);
    loadCheck("lw 020 merged", 3'b010, 11'h020, 32'h123455AA);

    access("sw 030", 1'b0, 1'b1, 3'b010, 11'h030, 32'h11223344);
    access("sh 031 misaligned", 1'b0, 1'b1, 3'b001, 11'h031, 32'hFFFFFFFF);
    checkOutput("sh 031 fault literal", {31'b0, fault}, 32'd1);
    access("sw 032 misaligned", 1'b0, 1'b1, 3'b010, 11'h032, 32'hFFFFFFFF);
    checkOutput("sw 032 fault literal", {31'b0, fault}, 32'd1);
    access("lw 033 misaligned", 1'b1, 1'b0, 3'b010, 11'h033, 32'h0);
    checkOutput("lw 033 fault literal", {31'b0, fault}, 32'd1);
    access("f3 011 illegal", 1'b1, 1'b1, 3'b011, 11'h030, 32'hFFFFFFFF);
    checkOutput("f3 011 fault literal", {31'b0, fault}, 32'd1);
    access("store f3 100 illegal", 1'b0, 1'b1, 3'b100, 11'h030, 32'hFFFFFFFF);
    loadCheck("lw 030 unchanged", 3'b010, 11'h030, 32'h11223344);

    access("lw 400 oor", 1'b1, 1'b0, 3'b010, 11'h400, 32'h0);
    checkOutput("lw 400 fault literal", {31'b0, fault}, 32'd1);
    access("sw 400 oor", 1'b0, 1'b1, 3'b010, 11'h400, 32'h5A5A5A5A);
    checkOutput("sw 400 fault literal", {31'b0, fault}, 32'd1);
    access("sw 7FC oor", 1'b0, 1'b1, 3'b010, 11'h7FC, 32'hA5A5A5A5);
    loadCheck("lw 000 after oor", 3'b010, 11'h000, 32'h0);
    loadCheck("lw 3FC after oor", 3'b010, 11'h3FC, 32'h0);

    access("rw 040", 1'b1, 1'b1, 3'b010, 11'h040, 32'hDEADBEEF);
    checkOutput("rw 040 old literal", read_data, 32'h0);
    loadCheck("lw 040 new", 3'b010, 11'h040, 32'hDEADBEEF);

    for (int i = 0; i < 600; i++) begin
      rd = ($urandom_range(0, 3) != 0);
      wr = ($urandom_range(0, 1) != 0);
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) f3 = legal_codes[$urandom_range(0, 4)];
      a = 11'($urandom_range(0, 2047));
      if ($urandom_range(0, 7) != 0) a[10] = 1'b0;
      if ($urandom_range(0, 1) != 0) a = a & 11'h07F;
      if ($urandom_range(0, 1) != 0) a = a & ~11'(size_of(f3) - 1);
      access("rand", rd, wr, f3, a, $urandom);
    end

    access("nc sw 040", 1'b0, 1'b1, 3'b010, 11'h040, 32'hDEADBEEF);
    pulseReset();
    #1;
    checkOutput("nc ready after release", {31'b0, nc_ready}, 32'd1);
    checkOutput("main ready after release", {31'b0, ready}, 32'd0);
    applyStimulus(1'b1, 1'b0, 3'b010, 11'h040, 32'h0);
    checkOutput("nc lw 040 retained", nc_read_data, 32'hDEADBEEF);
    checkOutput("nc lw 040 fault", {31'b0, nc_fault}, 32'd0);
    checkOutput("main lw during clear", read_data, 32'h0);
    applyStimulus(1'b0, 1'b0, 3'b000, 11'h000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/dmem_bytelane.md
Name: dmem_bytelane

Overview:
- Parametrised data memory for the single-cycle RV32 core, replacing the fixed 256-word D-MEM.
- Uses byte addressing with RV32 load/store sizing selected by funct3: byte, halfword and word accesses, with sign/zero extension on loads.
- Detects misaligned, illegal and out-of-range accesses.
- Runs a sequenced post-reset clear FSM and signals completion through `ready`.
- Sits between ALU result/rs2 and the writeback mux; combinational read, synchronous write.

Parameters:
- DEPTH, 256, number of 32-bit words; must be a power of two, at least 2.
- ADDR_WIDTH, 10, byte-address width; must satisfy 2^ADDR_WIDTH >= 4*DEPTH.
- CLEAR_ON_RESET, 1, 1 = zero all DEPTH words after reset; 0 = contents retained through reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- mem_read  in  1  load request, combinational read.
- mem_write  in  1  store request, committed at rising edge.
- funct3  in  3  RV32 load/store size/sign code.
- addr  in  ADDR_WIDTH  byte address.
- write_data  in  32  store data; the lane source is its low bytes.
- read_data  out  32  load result, extended per funct3.
- ready  out  1  memory usable; 0 while clearing or in reset.
- fault  out  1  current access is misaligned, illegal or out of range.

Behaviour:
- Clock and reset: one clock, `clk`. Reset is synchronous and active-high on `reset`; it is sampled only at the rising edge of `clk`.
- FSM states: CLEAR, IDLE.
  - reset=1 at an edge: next state = CLEAR (CLEAR_ON_RESET=1) or IDLE (CLEAR_ON_RESET=0); clr_ptr <= 0.
  - While reset is high: ready=0, read_data=0, fault=0, no writes occur.
  - CLEAR: each edge writes word[clr_ptr] <= 0 and increments clr_ptr. At clr_ptr==DEPTH-1 the final word is zeroed and the next state is IDLE.
  - Clear therefore takes exactly DEPTH cycles after reset deasserts. ready rises in the first IDLE cycle.
  - reset reasserted mid-CLEAR restarts the clear at clr_ptr=0.
  - In CLEAR, mem_read/mem_write are ignored: read_data=0, fault=0.
  - IDLE: ready=1. Only reset leaves this state.
- Word index = addr[ADDR_WIDTH-1:2]; lane = addr[1:0].
  - out_of_range = word index >= DEPTH.
- Loads (ready & mem_read), combinational, no latency:
  - 000 LB: sign-extend byte at lane.
  - 001 LH: sign-extend half at lane (lane[0] must be 0).
  - 010 LW: full word (lane must be 00).
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Other funct3 codes are illegal.
- Stores (ready & mem_write), at the rising edge:
  - 000 SB: write write_data[7:0] into byte lane `lane`.
  - 001 SH: write write_data[15:0] into lanes {addr[1],0} and {addr[1],1}.
  - 010 SW: write all four lanes.
  - Other funct3 codes are illegal. Unselected lanes are unchanged.
- fault (combinational) = ready & (mem_read | mem_write) & (misaligned | illegal funct3 | out_of_range).
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=00.
  - On fault: the write is suppressed and read_data=0.
- read_data = 0 whenever there is no valid load: mem_read=0, not ready, or fault. It never goes X.
- mem_read & mem_write in the same cycle are legal:
  - read_data shows the pre-write contents for the whole cycle.
  - The store commits at the edge; the next cycle shows the new value.
  - The funct3 decode applies to both.
- With CLEAR_ON_RESET=0: contents are preserved across reset, and ready=1 in the first cycle after reset deasserts.

Test Plan:
- DEPTH=256, CLEAR_ON_RESET=1: preload via SW, assert reset 1 cycle, release -> ready=0 for exactly 256 cycles, then ready=1. LW of addr 0x000, 0x1FC, 0x3FC returns 0x00000000. Reasserting reset at clear cycle 100 restarts the full 256-cycle count.
- SW 0x80FF7F01 @0x010, then LB/LBU/LH/LHU @0x010..0x013:
  - LB @0x010 = 0x00000001.
  - LB @0x011 = 0x0000007F.
  - LB @0x012 = 0xFFFFFFFF; LBU @0x012 = 0x000000FF.
  - LB @0x013 = 0xFFFFFF80.
  - LH @0x012 = 0xFFFF80FF; LHU @0x012 = 0x000080FF.
- SW 0xAAAAAAAA @0x020; SB 0x55 @0x021; SH 0x1234 @0x022 -> LW @0x020 = 0x12345555? No: expected 0x123455AA.
- Misaligned and illegal: SH @0x031, SW @0x032, LW @0x033, funct3=011 @0x030 -> fault=1 in each case, read_data=0, and memory @0x030 is unchanged (verified by an LW afterwards).
- Out of range: LW/SW @0x400 with ADDR_WIDTH=11 -> fault=1, no write; a subsequent LW @0x000 is unaffected.
- mem_read=mem_write=1, SW 0xDEADBEEF @0x040 (old 0x0) -> read_data=0x00000000 that cycle, 0xDEADBEEF the next cycle. With CLEAR_ON_RESET=0, the value survives a reset pulse and ready=1 one cycle after release.
